// File: rtl/mem_responder.sv
// mem_responder
// -----------------------------------------------------------------------------
// Memory-side responder for the multicycle datapath memory port. It accepts one
// read or write request at a time and serves it from an internal word array
// after a fixed latency. Completion is flagged with a one-cycle ready pulse.
// This lets the control FSM use a handshake instead of hard-coded memory-delay
// states. The responder sits between the IorD address mux / B register and the
// MDR/IR load path.
//
// Parameters:
//   DEPTH_WORDS   - number of 32-bit words in the array (word index = Address[31:2])
//   READ_LATENCY  - clock edges from acceptance to read data capture (1..15)
//   WRITE_LATENCY - clock edges from acceptance to array write commit (1..15)
//
// Ports:
//   Clk          in   1  the only clock
//   Reset_signal in   1  synchronous, active-high reset
//   req          in   1  request valid, sampled only in IDLE
//   wr           in   1  1 = write, 0 = read, sampled with req
//   Address      in  32  byte address, sampled with req
//   WriteData    in  32  store data, sampled with req
//   ReadData     out 32  read result, held until the next read completes
//   ready        out  1  one-cycle completion pulse (reads and writes)
//   busy         out  1  high whenever the state is not IDLE
//   error        out  1  one-cycle fault pulse coincident with ready
//   StateOut     out  2  current state encoding (IDLE=0, WAIT=1, DONE=2)
//
// Optional feature:
//   MEM_RESP_ALIGN_CHECK_EN - when defined, a non-word-aligned address
//   (Address[1:0] != 0) at acceptance faults the access. When undefined, the
//   low address bits are ignored.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH_WORDS   = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset_signal,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        busy,
  output logic        error,
  output logic [1:0]  StateOut
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [30:0] DEPTH_LIM = 31'(DEPTH_WORDS);
  localparam logic [3:0]  RD_LOAD   = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  WR_LOAD   = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          wr_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          fault_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          busy_q;
  logic          error_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          inRange;
  logic          fault_d;
  logic          commit;

  // The range test uses the full word index. Only the low AW bits are kept
  // afterwards, because an out-of-range access never touches the array.
  assign inRange = ({1'b0, Address[31:2]} < DEPTH_LIM);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign fault_d = !inRange || (Address[1:0] != 2'b00);
`else
  assign fault_d = !inRange;

  // The byte-offset bits are intentionally ignored in this build.
  logic unusedAlignBits;
  assign unusedAlignBits = ^Address[1:0];
`endif

  // The access edge is the WAIT edge on which the counter has drained to zero.
  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);

  // Array write port. It is kept out of the reset branch so the array is never
  // cleared. Reset on the commit edge suppresses the write, which aborts the
  // access cleanly.
  always_ff @(posedge Clk) begin
    if (!Reset_signal && commit && wr_q && !fault_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Control FSM with registered outputs. ready/error are asserted on the edge
  // that enters DONE, so they are high exactly while the state is DONE.
  // busy rises on acceptance and falls on the return to IDLE.
  always_ff @(posedge Clk) begin
    if (Reset_signal) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          if (req) begin
            wr_q    <= wr;
            idx_q   <= Address[AW+1:2];
            wdata_q <= WriteData;
            fault_q <= fault_d;
            cnt_q   <= wr ? WR_LOAD : RD_LOAD;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!wr_q) begin
              rdata_q <= fault_q ? 32'd0 : mem[idx_q];
            end
            ready_q <= 1'b1;
            error_q <= fault_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ReadData = rdata_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign error    = error_q;
  assign StateOut = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// -----------------------------------------------------------------------------
// Directed self-checking bench for mem_responder with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge. Expected
// values are hand-computed constants. Define MEM_RESP_ALIGN_CHECK_EN to
// exercise the alignment-fault build.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic        Clk;
  logic        Reset_signal;
  logic        req;
  logic        wr;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ready;
  logic        busy;
  logic        error;
  logic [1:0]  StateOut;

  int compared;
  int mismatched;

  int          lastCyc;
  logic [31:0] lastRd;
  logic        lastErr;
  logic        busyN1;
  logic [1:0]  stateN1;
  logic        readyAfter;
  logic        busyAfter;
  logic [31:0] rdAfter;

  mem_responder dut (
    .Clk          (Clk),
    .Reset_signal (Reset_signal),
    .req          (req),
    .wr           (wr),
    .Address      (Address),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .ready        (ready),
    .busy         (busy),
    .error        (error),
    .StateOut     (StateOut)
  );

  // 10-unit clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard stop in case a wait is never satisfied.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on a mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
  endtask

  // Issue one request and follow it to completion. Fields sampled one cycle
  // after acceptance, at the ready pulse and one cycle after it are left in
  // the last*/N1/After variables. lastCyc counts falling edges after the
  // driving edge until ready is seen (-1 on timeout).
  task automatic applyStimulus(input logic wrIn, input logic [31:0] addr,
                               input logic [31:0] data);
    bit found;
    @(negedge Clk);
    req       = 1'b1;
    wr        = wrIn;
    Address   = addr;
    WriteData = data;
    @(negedge Clk);
    req     = 1'b0;
    busyN1  = busy;
    stateN1 = StateOut;
    lastCyc = -1;
    lastRd  = 32'd0;
    lastErr = 1'b0;
    found   = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      if (i > 1) @(negedge Clk);
      if (ready) begin
        found   = 1'b1;
        lastCyc = i;
        lastRd  = ReadData;
        lastErr = error;
      end
    end
    @(negedge Clk);
    readyAfter = ready;
    busyAfter  = busy;
    rdAfter    = ReadData;
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    Reset_signal = 1'b1;
    req          = 1'b0;
    wr           = 1'b0;
    Address      = 32'd0;
    WriteData    = 32'd0;

    // Reset then idle
    repeat (2) @(negedge Clk);
    Reset_signal = 1'b0;
    checkOutput("rst_ReadData", ReadData, 32'd0);
    checkOutput("rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_StateOut", {30'd0, StateOut}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checkOutput("idle_outputs", {ReadData[27:0], ready, busy, error, 1'b0} | {30'd0, StateOut},
                  32'd0);
    end

    // Write 0xDEADBEEF to 0x10
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF);
    checkOutput("wr10_latency", 32'(lastCyc), 32'd3);
    checkOutput("wr10_error", {31'd0, lastErr}, 32'd0);
    checkOutput("wr10_busy_wait", {31'd0, busyN1}, 32'd1);
    checkOutput("wr10_state_wait", {30'd0, stateN1}, 32'd1);
    checkOutput("wr10_ready_after", {31'd0, readyAfter}, 32'd0);
    checkOutput("wr10_busy_after", {31'd0, busyAfter}, 32'd0);

    // Read 0x10 back; data holds after the pulse
    applyStimulus(1'b0, 32'h10, 32'h0);
    checkOutput("rd10_latency", 32'(lastCyc), 32'd3);
    checkOutput("rd10_data", lastRd, 32'hDEADBEEF);
    checkOutput("rd10_hold", rdAfter, 32'hDEADBEEF);
    checkOutput("rd10_error", {31'd0, lastErr}, 32'd0);

    // Busy rejection: a write issued during WAIT, and req still high in DONE
    @(negedge Clk);
    req = 1'b1; wr = 1'b0; Address = 32'h10; WriteData = 32'h0;
    @(negedge Clk);
    checkOutput("busyrej_state_wait", {30'd0, StateOut}, 32'd1);
    wr = 1'b1; WriteData = 32'h12345678;
    @(negedge Clk);
    checkOutput("busyrej_ready_early", {31'd0, ready}, 32'd0);
    @(negedge Clk);
    checkOutput("busyrej_ready", {31'd0, ready}, 32'd1);
    checkOutput("busyrej_data", ReadData, 32'hDEADBEEF);
    checkOutput("busyrej_state_done", {30'd0, StateOut}, 32'd2);
    @(negedge Clk);
    checkOutput("busyrej_state_idle", {30'd0, StateOut}, 32'd0);
    req = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0);
    checkOutput("busyrej_readback", lastRd, 32'hDEADBEEF);

    // Out of range, plus the last legal word
    applyStimulus(1'b1, 32'h0, 32'hA5A5A5A5);
    applyStimulus(1'b1, 32'h3FC, 32'h13579BDF);
    checkOutput("wr3fc_error", {31'd0, lastErr}, 32'd0);
    applyStimulus(1'b1, 32'h400, 32'h55);
    checkOutput("wr400_latency", 32'(lastCyc), 32'd3);
    checkOutput("wr400_error", {31'd0, lastErr}, 32'd1);
    applyStimulus(1'b0, 32'h400, 32'h0);
    checkOutput("rd400_data", lastRd, 32'd0);
    checkOutput("rd400_error", {31'd0, lastErr}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("rd0_data", lastRd, 32'hA5A5A5A5);
    checkOutput("rd0_error", {31'd0, lastErr}, 32'd0);
    applyStimulus(1'b0, 32'h3FC, 32'h0);
    checkOutput("rd3fc_data", lastRd, 32'h13579BDF);

    // Reset on the commit edge of a write
    applyStimulus(1'b1, 32'h20, 32'h01020304);
    @(negedge Clk);
    req = 1'b1; wr = 1'b1; Address = 32'h20; WriteData = 32'hCAFEF00D;
    @(negedge Clk);
    req = 1'b0;
    @(negedge Clk);
    Reset_signal = 1'b1;
    @(negedge Clk);
    checkOutput("rstmid_ready", {31'd0, ready}, 32'd0);
    checkOutput("rstmid_state", {30'd0, StateOut}, 32'd0);
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    Reset_signal = 1'b0;
    applyStimulus(1'b0, 32'h20, 32'h0);
    checkOutput("rstmid_readback", lastRd, 32'h01020304);

    // Misaligned write to 0x13 (word 0x10)
    applyStimulus(1'b1, 32'h13, 32'h11);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    checkOutput("align_wr_error", {31'd0, lastErr}, 32'd1);
    applyStimulus(1'b0, 32'h10, 32'h0);
    checkOutput("align_readback", lastRd, 32'hDEADBEEF);
`else
    checkOutput("align_wr_error", {31'd0, lastErr}, 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0);
    checkOutput("align_readback", lastRd, 32'h11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
